// File: rtl/c_damq_sched_pkg.sv
// Shared types and constants for the DAMQ pop scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c_damq_sched_pkg;

    typedef enum logic {
        SCHED_IDLE   = 1'b0,
        SCHED_LOCKED = 1'b1
    } sched_state_t;

    localparam int ERR_CREDIT_OVF = 0;
    localparam int ERR_BAD_POP    = 1;

    localparam int RESET_TYPE_ASYNC = 0;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/c_damq_credit_counter.sv
// Per-queue downstream credit counter: saturating up/down count, nonzero flag, sticky overflow error.
// Latency: count and error update on the clk edge after inc/dec.
// Backpressure: none; nonzero gates eligibility of the queue in the scheduler.
module c_damq_credit_counter
    import c_damq_sched_pkg::*;
#(
    parameter int credit_depth = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic ovf_err
);

    localparam int CW = credit_width(credit_depth);
    localparam logic [CW-1:0] FULL = CW'(credit_depth);

    logic [CW-1:0] cnt_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r   <= FULL;
            ovf_err <= 1'b0;
        end else if (active) begin
            if (inc && !dec) begin
                // A return into a full counter saturates instead of wrapping.
                if (cnt_r == FULL) begin
                    ovf_err <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else if (dec && !inc && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign nonzero = (cnt_r != '0);

endmodule

// File: rtl/c_damq_pop_scheduler.sv
// DAMQ output scheduler: round-robin pop over non-empty queues with credits; optional packet lock (C_DAMQ_SCHED_PKT_LOCK_EN).
// Latency: pop_valid/pop_sel_qu combinational from registered state; state updates on the next clk edge.
// Backpressure: nothing pops while out_ready or active is low, or a queue is out of credits.
module c_damq_pop_scheduler
    import c_damq_sched_pkg::*;
#(
    parameter int num_queues   = 4,
    parameter int credit_depth = 8,
    parameter int reset_type   = RESET_TYPE_ASYNC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      active,
    input  logic [0:num_queues-1]     empty_qu,
    input  logic                      pop_tail,
    input  logic                      out_ready,
    input  logic                      credit_valid,
    input  logic [0:num_queues-1]     credit_sel_qu,
    output logic                      pop_valid,
    output logic [0:num_queues-1]     pop_sel_qu,
    output logic [0:num_queues-1]     credits_avail_qu,
    output logic [0:num_queues*2-1]   errors_qu
);

    localparam int PW = $clog2(num_queues);
    localparam logic [PW-1:0] LAST = PW'(num_queues - 1);

    // Only the asynchronous reset flavour exists; other values elaborate to nothing extra.
    if (reset_type != RESET_TYPE_ASYNC) begin : g_unsupported_reset_type
    end

    logic [0:num_queues-1] nonzero;
    logic [0:num_queues-1] ovf;
    logic [0:num_queues-1] bad_pop_r;
    logic [0:num_queues-1] eligible;
    logic [0:num_queues-1] lock_mask;
    logic [PW-1:0]         ptr_r;
    logic [PW-1:0]         ptr_nxt;
    logic [PW-1:0]         grant_idx;
    logic [PW-1:0]         grant_next;
    logic                  grant_any;

    always_comb begin
        for (int q = 0; q < num_queues; q++) begin
            eligible[q] = !empty_qu[q] && nonzero[q] && lock_mask[q] && out_ready && active;
        end
    end

    // Walk from the pointer upwards with wrap; the first eligible queue wins.
    always_comb begin
        int q;
        q         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < num_queues; i++) begin
            q = (int'(ptr_r) + i) % num_queues;
            if (!grant_any && eligible[q]) begin
                grant_any = 1'b1;
                grant_idx = PW'(q);
            end
        end
    end

    always_comb begin
        pop_sel_qu = '0;
        if (grant_any) begin
            pop_sel_qu[grant_idx] = 1'b1;
        end
    end

    assign pop_valid  = grant_any;
    assign grant_next = (grant_idx == LAST) ? '0 : grant_idx + PW'(1);

`ifdef C_DAMQ_SCHED_PKT_LOCK_EN
    sched_state_t  state_r;
    sched_state_t  state_nxt;
    logic [PW-1:0] lock_q_r;
    logic [PW-1:0] lock_q_nxt;

    always_comb begin
        lock_mask = '1;
        if (state_r == SCHED_LOCKED) begin
            lock_mask           = '0;
            lock_mask[lock_q_r] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state_r;
        lock_q_nxt = lock_q_r;
        ptr_nxt    = ptr_r;
        if (grant_any) begin
            case (state_r)
                SCHED_IDLE: begin
                    ptr_nxt = grant_next;
                    if (!pop_tail) begin
                        state_nxt  = SCHED_LOCKED;
                        lock_q_nxt = grant_idx;
                    end
                end
                SCHED_LOCKED: begin
                    // Pointer stays parked until the tail leaves the locked queue.
                    if (pop_tail) begin
                        state_nxt = SCHED_IDLE;
                        ptr_nxt   = grant_next;
                    end
                end
                default: state_nxt = SCHED_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= SCHED_IDLE;
            lock_q_r <= '0;
        end else if (active) begin
            state_r  <= state_nxt;
            lock_q_r <= lock_q_nxt;
        end
    end
`else
    logic unused_pop_tail;

    assign unused_pop_tail = pop_tail;
    assign lock_mask       = '1;
    assign ptr_nxt         = grant_any ? grant_next : ptr_r;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (active) begin
            ptr_r <= ptr_nxt;
        end
    end

    for (genvar q = 0; q < num_queues; q++) begin : g_q
        c_damq_credit_counter #(
            .credit_depth(credit_depth)
        ) u_credit_counter (
            .clk    (clk),
            .reset  (reset),
            .active (active),
            .inc    (credit_valid && credit_sel_qu[q]),
            .dec    (pop_sel_qu[q]),
            .nonzero(nonzero[q]),
            .ovf_err(ovf[q])
        );

        // Consistency check on the arbiter itself: a grant must never pick an unusable queue.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                bad_pop_r[q] <= 1'b0;
            end else if (active && pop_sel_qu[q] && (empty_qu[q] || !nonzero[q])) begin
                bad_pop_r[q] <= 1'b1;
            end
        end

        assign errors_qu[2*q + ERR_CREDIT_OVF] = ovf[q];
        assign errors_qu[2*q + ERR_BAD_POP]    = bad_pop_r[q];
    end

    assign credits_avail_qu = nonzero;

endmodule

// File: tb/tb_c_damq_pop_scheduler.sv
// Directed bench for c_damq_pop_scheduler with a queue-level reference model checked every cycle.
// Lock scenarios are exercised only when C_DAMQ_SCHED_PKT_LOCK_EN is defined.
module tb_c_damq_pop_scheduler;

    localparam int NQ = 4;
    localparam int D  = 8;
`ifdef C_DAMQ_SCHED_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk          = 1'b0;
    logic            reset        = 1'b1;
    logic            active       = 1'b0;
    logic [0:NQ-1]   empty_qu     = '1;
    logic            pop_tail     = 1'b1;
    logic            out_ready    = 1'b0;
    logic            credit_valid = 1'b0;
    logic [0:NQ-1]   credit_sel_qu = '0;
    logic            pop_valid;
    logic [0:NQ-1]   pop_sel_qu;
    logic [0:NQ-1]   credits_avail_qu;
    logic [0:2*NQ-1] errors_qu;

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    c_damq_pop_scheduler #(
        .num_queues  (NQ),
        .credit_depth(D)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .active          (active),
        .empty_qu        (empty_qu),
        .pop_tail        (pop_tail),
        .out_ready       (out_ready),
        .credit_valid    (credit_valid),
        .credit_sel_qu   (credit_sel_qu),
        .pop_valid       (pop_valid),
        .pop_sel_qu      (pop_sel_qu),
        .credits_avail_qu(credits_avail_qu),
        .errors_qu       (errors_qu)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers per queue.
    int m_ptr;
    int m_cred[NQ];
    bit m_ovf[NQ];
    bit m_locked;
    int m_lock_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_pick(output bit v, output int g);
        v = 1'b0;
        g = 0;
        for (int i = 0; i < NQ; i++) begin
            int  q;
            bit  ok;
            q  = (m_ptr + i) % NQ;
            ok = !empty_qu[q] && (m_cred[q] > 0) && out_ready && active;
            if (LOCK_EN && m_locked && (q != m_lock_q)) ok = 1'b0;
            if (!v && ok) begin
                v = 1'b1;
                g = q;
            end
        end
    endfunction

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 1'b0;
        m_lock_q = 0;
        for (int q = 0; q < NQ; q++) begin
            m_cred[q] = D;
            m_ovf[q]  = 1'b0;
        end
    endtask

    task automatic model_step();
        bit v;
        int g;
        model_pick(v, g);
        for (int q = 0; q < NQ; q++) begin
            bit inc;
            bit dec;
            inc = credit_valid && credit_sel_qu[q];
            dec = v && (g == q);
            if (inc && !dec) begin
                if (m_cred[q] == D) m_ovf[q] = 1'b1;
                else                m_cred[q]++;
            end else if (dec && !inc) begin
                m_cred[q]--;
            end
        end
        if (v) begin
            if (!LOCK_EN) begin
                m_ptr = (g + 1) % NQ;
            end else if (!m_locked) begin
                m_ptr = (g + 1) % NQ;
                if (!pop_tail) begin
                    m_locked = 1'b1;
                    m_lock_q = g;
                end
            end else if (pop_tail) begin
                m_locked = 1'b0;
                m_ptr    = (g + 1) % NQ;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset)      model_reset();
            else if (active) model_step();
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    initial begin
        forever begin
            bit              v;
            int              g;
            logic [0:NQ-1]   exp_sel;
            logic [0:NQ-1]   exp_av;
            logic [0:2*NQ-1] exp_err;
            @(negedge clk);
            if (!done) begin
                model_pick(v, g);
                exp_sel = '0;
                if (v) exp_sel[g] = 1'b1;
                exp_err = '0;
                for (int q = 0; q < NQ; q++) begin
                    exp_av[q]      = (m_cred[q] > 0);
                    exp_err[2*q]   = m_ovf[q];
                end
                check("cyc_pop_valid", pop_valid, v);
                check("cyc_pop_sel", pop_sel_qu, exp_sel);
                check("cyc_credits_avail", credits_avail_qu, exp_av);
                check("cyc_errors", errors_qu, exp_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input string name, input logic [0:NQ-1] e);
        @(negedge clk);
        check(name, pop_sel_qu, e);
        check({name, "_valid"}, pop_valid, |e);
        tick();
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        check(name, pop_valid, 1'b0);
        tick();
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_pop_valid", pop_valid, 1'b0);
        check("rst_pop_sel", pop_sel_qu, 4'b0000);
        check("rst_credits", credits_avail_qu, 4'b1111);
        check("rst_errors", errors_qu, 8'h00);
        tick();
        reset     = 1'b1;
        active    = 1'b1;
        out_ready = 1'b1;

        // All queues busy: plain rotation.
        empty_qu = 4'b0000;
        expect_pop("rr_q0", 4'b1000);
        expect_pop("rr_q1", 4'b0100);
        expect_pop("rr_q2", 4'b0010);
        expect_pop("rr_q3", 4'b0001);
        expect_pop("rr_q0_again", 4'b1000);
        empty_qu = 4'b1111;
        check("model_cred_q0", m_cred[0], 6);
        check("model_cred_q1", m_cred[1], 7);

        // Drain queue 2 of its 7 remaining credits.
        empty_qu = 4'b1101;
        repeat (7) expect_pop("drain_q2", 4'b0010);
        @(negedge clk);
        check("drained_no_pop", pop_valid, 1'b0);
        check("drained_avail", credits_avail_qu, 4'b1101);
        tick();
        credit_valid  = 1'b1;
        credit_sel_qu = 4'b0010;
        expect_idle("return_cycle_no_pop");
        credit_valid = 1'b0;
        expect_pop("pop_after_return", 4'b0010);
        expect_idle("drained_again");
        empty_qu     = 4'b1111;
        credit_valid = 1'b1;
        repeat (8) tick();
        credit_valid = 1'b0;
        check("model_cred_q2_full", m_cred[2], 8);

        // Simultaneous pop and return on queue 1, then overflow it.
        empty_qu      = 4'b1011;
        credit_valid  = 1'b1;
        credit_sel_qu = 4'b0100;
        expect_pop("pop_and_return_q1", 4'b0100);
        empty_qu = 4'b1111;
        check("model_cred_q1_same", m_cred[1], 7);
        tick();
        tick();
        credit_valid = 1'b0;
        @(negedge clk);
        check("ovf_err_q1", errors_qu, 8'b0010_0000);
        tick();
        tick();
        @(negedge clk);
        check("ovf_err_sticky", errors_qu, 8'b0010_0000);
        tick();
        credit_valid  = 1'b1;
        credit_sel_qu = 4'b1000;
        tick();
        tick();
        credit_sel_qu = 4'b0001;
        tick();
        credit_valid = 1'b0;

        // Clock enable low: nothing moves.
        empty_qu = 4'b0000;
        active   = 1'b0;
        repeat (3) expect_idle("inactive_no_pop");
        check("model_cred_q3_held", m_cred[3], 8);
        active = 1'b1;
        expect_pop("resume_q2", 4'b0010);
        expect_pop("resume_q3", 4'b0001);

`ifdef C_DAMQ_SCHED_PKT_LOCK_EN
        empty_qu = 4'b0111;
        expect_pop("lk_pre_q0", 4'b1000);
        empty_qu = 4'b0001;
        pop_tail = 1'b0;
        expect_pop("lk_q1_f0", 4'b0100);
        expect_pop("lk_q1_f1", 4'b0100);
        pop_tail = 1'b1;
        expect_pop("lk_q1_tail", 4'b0100);
        expect_pop("lk_then_q2", 4'b0010);
        empty_qu = 4'b0000;
        pop_tail = 1'b0;
        expect_pop("lk_q3_head", 4'b0001);
        empty_qu = 4'b0001;
        repeat (2) expect_idle("lk_q3_empty_hold");
        empty_qu = 4'b0000;
        expect_pop("lk_q3_refill", 4'b0001);
`endif

        // Reset in the middle of traffic.
        reset    = 1'b0;
        empty_qu = 4'b1111;
        @(negedge clk);
        check("mid_rst_pop_valid", pop_valid, 1'b0);
        check("mid_rst_pop_sel", pop_sel_qu, 4'b0000);
        check("mid_rst_credits", credits_avail_qu, 4'b1111);
        check("mid_rst_errors", errors_qu, 8'h00);
        tick();
        reset    = 1'b1;
        empty_qu = 4'b0000;
        pop_tail = 1'b1;
        expect_pop("post_rst_q0", 4'b1000);
        expect_pop("post_rst_q1", 4'b0100);
        check("model_cred_post_rst", m_cred[0], 7);

        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        bad++;
        $display("FAIL watchdog: sequence still running at t=%0t, wanted completion", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/c_damq_pop_scheduler.md
# c_damq_pop_scheduler

Output-side scheduler for a dynamically allocated multi-queue (DAMQ) buffer. It selects which queue to pop each cycle using round-robin arbitration over queues that are non-empty and hold downstream credits. It tracks per-queue downstream credits and, optionally, holds a queue until its packet tail has been popped. It sits between the DAMQ buffer-state tracker (flags in, pop request out) and the downstream link (credit returns in, ready in).

## Interface
Parameters:
- num_queues, 4, number of DAMQ queues (≥2)
- credit_depth, 8, downstream credits per queue at reset (≥1)
- reset_type, `RESET_TYPE_ASYNC`, fixed; the block supports only the asynchronous reset

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low: low asserts, high releases
- active  in  1  clock enable for all state
- empty_qu  in  [0:num_queues-1]  registered empty flags from the tracker
- pop_tail  in  1  the head entry of the currently selected queue is a packet tail (valid with pop_valid)
- out_ready  in  1  downstream can accept a flit this cycle
- credit_valid  in  1  downstream returns one credit
- credit_sel_qu  in  [0:num_queues-1]  one-hot queue for the returned credit
- pop_valid  out  1  pop one entry this cycle
- pop_sel_qu  out  [0:num_queues-1]  one-hot queue to pop; all zero when pop_valid is low
- credits_avail_qu  out  [0:num_queues-1]  queue has at least one credit
- errors_qu  out  [0:num_queues*2-1]  per queue: [2q] credit overflow, [2q+1] pop while empty or without credit

## Operation
- A queue is eligible when it is not empty, has a nonzero credit count, and out_ready and active are both high.
- Round-robin arbitration:
  - A pointer holds the highest-priority queue; priority descends from the pointer and wraps from num_queues-1 to 0.
  - pop_sel_qu is the first eligible queue in that order.
  - pop_valid is high when any queue is eligible.
- After a grant, the pointer moves to (granted + 1) mod num_queues. It is unchanged when nothing is granted.
- Credit counters:
  - Each queue has a counter of width clog2(credit_depth+1), reset to credit_depth.
  - A pop alone decrements the counter; a credit return alone increments it; both in the same cycle leave it unchanged.
  - A return while the counter equals credit_depth saturates the counter and sets errors_qu[2q].
- errors_qu[2q+1] is set when the issued pop targets a queue that is empty or has a zero credit count. This is an internal consistency check and must never fire.
- Error bits are sticky; only reset clears them.
- When active is low: all state holds and pop_valid is forced to 0. Downstream must not assert credit_valid while active is low.
- Packet lock (when configured) uses two states:
  - IDLE: normal arbitration. A grant with pop_tail low moves to LOCKED and records the granted queue.
  - LOCKED(q): only q is eligible, and the pointer does not move. A grant of q with pop_tail high returns to IDLE and sets the pointer to q+1.
  - If q becomes empty or runs out of credits while LOCKED, the state stays LOCKED and pop_valid is 0.
- Reset during operation returns all state to reset values, drops any lock, and restores all credits. Flits in flight are the system's responsibility.

## Timing
- pop_valid and pop_sel_qu are combinational from registered state (pointer, credits, lock state) and the current-cycle inputs. There is zero-cycle latency from flags to pop.
- Pointer, counters, lock state and errors update on the rising clk edge following the grant or credit return.
- A credit returned in cycle t is usable for a pop in cycle t+1.
- A queue popped to zero credits in cycle t is ineligible from cycle t+1.
- empty_qu is registered in the tracker, so a pop of a queue's last entry in cycle t shows as empty in t+1. No hazard exists.
- Reset values:
  - pop_valid 0, pop_sel_qu 0
  - credits_avail_qu all 1
  - errors_qu 0
  - pointer 0, state IDLE

## Configuration
- C_DAMQ_SCHED_PKT_LOCK_EN:
  - Defined: the IDLE/LOCKED packet-lock state machine is compiled in, and pop_tail is honoured.
  - Undefined: per-flit round-robin, no lock state, pop_tail ignored, and the pointer advances after every grant.

## Structure
- Package c_damq_sched_pkg holds:
  - the state enum typedef (SCHED_IDLE, SCHED_LOCKED)
  - the error-bit index constants (ERR_CREDIT_OVF=0, ERR_BAD_POP=1)
  - a credit-width function
- Sub-module c_damq_credit_counter is instantiated once per queue. It covers one saturating up/down counter, the nonzero flag and the overflow error.
- The round-robin priority selection and lock FSM live in the top module.

## Test plan
- Reset, then all queues non-empty with out_ready=1 and lock disabled → pops 0,1,2,3,0 on consecutive cycles. Each counter decrements to 7 and then 6 for queue 0.
- Queue 2 only, credit_depth=2, no returns → two pops; pop_valid=0 from the third cycle and credits_avail_qu[2]=0. A return in cycle t gives a pop in t+1.
- Pop and credit return to queue 1 in the same cycle → counter unchanged. A return while the counter is at 8 → errors_qu[2] set and stays set until reset.
- With C_DAMQ_SCHED_PKT_LOCK_EN, queue 1 packet of 3 flits (tail on the 3rd) while queues 0 and 2 are non-empty → pops 1,1,1, then queue 2.
- Locked on queue 3 when empty_qu[3] rises → pop_valid=0 until queue 3 refills, with no other queue served. Assert reset low mid-lock → state IDLE, credits 8, outputs at reset values.
- active=0 for 3 cycles with eligible queues → pop_valid=0 and pointer and credits unchanged.
